// File: rtl/instruction_encoder.sv
// -----------------------------------------------------------------------------
// instruction_encoder
//   Packs decoded instruction fields into 32-bit RV32I instruction words. This
//   is the inverse of the immediate generator's field scatter. The LI pseudo-op
//   is expanded into ADDI, into LUI, or into LUI followed by ADDI.
//   There is one word of registered output, so a request's first word appears
//   one cycle after it is accepted.
//
// Parameters
//   LI_EXPAND  1: fmt LI expands to LUI/ADDI; 0: fmt LI is flagged illegal
//   ERR_ZERO   1: out_instr forced to 0 whenever out_err=1
//
// Ports
//   clk, rst_n               clock (rising edge), async active-low reset
//   in_valid / in_ready      request handshake
//   in_fmt                   0 R,1 I,2 S,3 B,4 U,5 J,6 LI,7 illegal
//   in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm
//                            decoded fields (in_imm is the full signed value)
//   out_valid / out_ready    word handshake
//   out_instr                encoded instruction word
//   out_err                  immediate out of range/misaligned, or illegal fmt
//   out_last                 last word of the current request
// -----------------------------------------------------------------------------
module instruction_encoder #(
    parameter bit LI_EXPAND = 1'b1,
    parameter bit ERR_ZERO  = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic        out_last
);

    localparam logic [6:0] OP_LUI  = 7'h37;
    localparam logic [6:0] OP_ADDI = 7'h13;

    // IDLE: no word held; ONE: holding a last word; FIRST: holding LUI, ADDI pending.
    typedef enum logic [1:0] {S_IDLE, S_ONE, S_FIRST} state_t;

    state_t      r_state;
    logic [31:0] r_instr;
    logic        r_err;
    logic        r_last;
    logic [31:0] r_pend;       // ADDI word waiting behind a LUI

    logic        w_accept;
    logic        w_fits12;
    logic        w_fits13;
    logic        w_fits21;
    logic [19:0] w_li_hi;
    logic [31:0] w_word;
    logic [31:0] w_second;
    logic        w_err;
    logic        w_two;

    // A value fits an N-bit signed field when every bit above N-1 matches the field's sign bit.
    assign w_fits12 = (in_imm[31:11] == {21{in_imm[11]}});
    assign w_fits13 = (in_imm[31:12] == {20{in_imm[12]}});
    assign w_fits21 = (in_imm[31:20] == {12{in_imm[20]}});

    // (imm + 0x800) >> 12. ADDI sign-extends its 12-bit operand, so the upper part
    // is rounded up whenever bit 11 of the low part is set.
    assign w_li_hi = in_imm[31:12] + {19'b0, in_imm[11]};

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_word   = '0;
        w_second = '0;
        w_err    = 1'b0;
        w_two    = 1'b0;
        case (in_fmt)
            3'd0: w_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            3'd1: begin
                w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                w_err  = !w_fits12;
            end
            3'd2: begin
                w_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                w_err  = !w_fits12;
            end
            3'd3: begin
                w_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                          in_imm[4:1], in_imm[11], in_opcode};
                w_err  = in_imm[0] || !w_fits13;
            end
            3'd4: begin
                w_word = {in_imm[31:12], in_rd, in_opcode};
                w_err  = |in_imm[11:0];
            end
            3'd5: begin
                w_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                w_err  = in_imm[0] || !w_fits21;
            end
            3'd6: begin
                if (!LI_EXPAND) begin
                    w_err = 1'b1;
                end else if (w_fits12) begin
                    w_word = {in_imm[11:0], 5'd0, 3'b000, in_rd, OP_ADDI};
                end else begin
                    w_word   = {w_li_hi, in_rd, OP_LUI};
                    w_second = {in_imm[11:0], in_rd, 3'b000, in_rd, OP_ADDI};
                    w_two    = |in_imm[11:0];   // a zero low part needs no ADDI
                end
            end
            default: w_err = 1'b1;
        endcase
        if (ERR_ZERO && w_err) begin
            w_word = '0;
        end
    end

    assign in_ready  = (r_state == S_IDLE) || ((r_state == S_ONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state != S_IDLE);
    assign out_instr = r_instr;
    assign out_err   = r_err;
    assign out_last  = r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_instr <= '0;
            r_err   <= 1'b0;
            r_last  <= 1'b0;
            r_pend  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every read in this block sees pre-edge values.
            case (r_state)
                S_FIRST: begin
                    if (out_ready) begin
                        r_state <= S_ONE;
                        r_instr <= r_pend;
                        r_err   <= 1'b0;
                        r_last  <= 1'b1;
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_state <= w_two ? S_FIRST : S_ONE;
                        r_instr <= w_word;
                        r_err   <= w_err;
                        r_last  <= !w_two;
                        r_pend  <= w_second;
                    end else if ((r_state == S_ONE) && out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// -----------------------------------------------------------------------------
// tb_instruction_encoder
//   Bench for instruction_encoder with default parameters.
//   Inputs change 2-3 time units after each rising edge. Outputs are sampled on
//   the falling edge. Every word the DUT hands over is compared against a
//   reference model that works on plain signed integers.
// -----------------------------------------------------------------------------
module tb_instruction_encoder;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } req_t;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic        last;
    } word_t;

    typedef struct {
        req_t        r;
        int          n;
        logic [31:0] w0;
        logic        e0;
        logic        l0;
        logic [31:0] w1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic        out_err;
    logic        out_last;
    req_t        cur = '0;

    bit          rand_mode = 1'b0;
    bit          ready_ctl = 1'b1;

    int          n_tests = 0;
    int          n_fail  = 0;

    word_t       exp_q[$];
    word_t       got_q[$];
    vec_t        vecs[$];

    instruction_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (cur.fmt),
        .in_opcode (cur.op),
        .in_rd     (cur.rd),
        .in_rs1    (cur.rs1),
        .in_rs2    (cur.rs2),
        .in_funct3 (cur.f3),
        .in_funct7 (cur.f7),
        .in_imm    (cur.imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    // Single driver of out_ready: a fixed level, or random 3/4-ready backpressure.
    always @(posedge clk) begin
        #3;
        out_ready = rand_mode ? ($urandom_range(0, 3) != 0) : ready_ctl;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void exp_push(input logic [31:0] w, input logic e, input logic l);
        word_t x;
        x.instr = w;
        x.err   = e;
        x.last  = l;
        exp_q.push_back(x);
    endfunction

    // Reference model: range rules checked on the signed integer value; LI split by arithmetic.
    function automatic void model_push(input req_t r);
        int          v;
        logic [31:0] i;
        logic [31:0] hi;
        logic [31:0] lo;
        v = $signed(r.imm);
        i = r.imm;
        case (r.fmt)
            3'd0: exp_push({r.f7, r.rs2, r.rs1, r.f3, r.rd, r.op}, 1'b0, 1'b1);
            3'd1: exp_push({i[11:0], r.rs1, r.f3, r.rd, r.op}, (v < -2048) || (v > 2047), 1'b1);
            3'd2: exp_push({i[11:5], r.rs2, r.rs1, r.f3, i[4:0], r.op}, (v < -2048) || (v > 2047), 1'b1);
            3'd3: exp_push({i[12], i[10:5], r.rs2, r.rs1, r.f3, i[4:1], i[11], r.op},
                           (i[0] == 1'b1) || (v < -4096) || (v > 4094), 1'b1);
            3'd4: exp_push({i[31:12], r.rd, r.op}, (i % 4096) != 0, 1'b1);
            3'd5: exp_push({i[20], i[10:1], i[11], i[19:12], r.rd, r.op},
                           (i[0] == 1'b1) || (v < -(1 << 20)) || (v > (1 << 20) - 2), 1'b1);
            3'd6: begin
                if (v >= -2048 && v <= 2047) begin
                    exp_push({i[11:0], 5'd0, 3'd0, r.rd, 7'h13}, 1'b0, 1'b1);
                end else begin
                    hi = (i + 32'h800) >> 12;
                    lo = i % 4096;
                    exp_push({hi[19:0], r.rd, 7'h37}, 1'b0, lo == 0);
                    if (lo != 0) exp_push({lo[11:0], r.rd, 3'd0, r.rd, 7'h13}, 1'b0, 1'b1);
                end
            end
            default: exp_push(32'h0, 1'b1, 1'b1);
        endcase
    endfunction

    // Monitor: scoreboard, hold stability under backpressure, in_ready rule.
    word_t hold_w;
    bit    hold_prev = 1'b0;
    always @(negedge clk) begin
        word_t w;
        word_t e;
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            check("in_ready", in_ready, !out_valid || (out_ready && out_last));
            if (hold_prev) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_instr", out_instr, hold_w.instr);
                check("hold_err", out_err, hold_w.err);
                check("hold_last", out_last, hold_w.last);
            end
            if (out_valid && out_ready) begin
                w.instr = out_instr;
                w.err   = out_err;
                w.last  = out_last;
                got_q.push_back(w);
                if (exp_q.size() == 0) begin
                    check("sb_pending", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_instr", out_instr, e.instr);
                    check("sb_err", out_err, e.err);
                    check("sb_last", out_last, e.last);
                end
            end
            if (in_valid && in_ready) model_push(cur);
            hold_prev    = out_valid && !out_ready;
            hold_w.instr = out_instr;
            hold_w.err   = out_err;
            hold_w.last  = out_last;
        end
    end

    function automatic req_t mk(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] imm);
        req_t r;
        r.fmt = fmt; r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
        r.f3 = f3; r.f7 = f7; r.imm = imm;
        return r;
    endfunction

    function automatic void addv(input req_t r, input int n, input logic [31:0] w0,
                                 input logic e0, input logic l0, input logic [31:0] w1);
        vec_t v;
        v.r = r; v.n = n; v.w0 = w0; v.e0 = e0; v.l0 = l0; v.w1 = w1;
        vecs.push_back(v);
    endfunction

    // Called just after a rising edge; returns once the request has been accepted.
    task automatic send(input req_t r, output int waits);
        waits    = 0;
        cur      = r;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) check("accept_wait", in_ready, 1'b1);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
        @(posedge clk);
        #2;
    endtask

    function automatic req_t rand_req();
        req_t r;
        r = req_t'({$urandom(), $urandom()});
        r.fmt = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 5))
            0: r.imm = $urandom_range(0, 4200) - 2100;
            1: r.imm = $urandom();
            2: r.imm = $urandom() & 32'hFFFF_F000;
            3: r.imm = ($urandom_range(0, 8400) - 4200) & 32'hFFFF_FFFE;
            4: r.imm = $urandom_range(0, (1 << 21) + 8) - (1 << 20) - 4;
            default: r.imm = {$urandom_range(0, 1) ? 21'h1F_FFFF : 21'h0, 11'($urandom())};
        endcase
        return r;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waits;
        // Hand-computed vectors (ERR_ZERO=0: error words still carry the truncated fields).
        addv(mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF), 1, 32'hFFF00093, 1'b0, 1'b1, 32'h0);
        addv(mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800), 1, 32'h80000093, 1'b0, 1'b1, 32'h0);
        addv(mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F7FF), 1, 32'h7FF00093, 1'b1, 1'b1, 32'h0);
        addv(mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8),         1, 32'h00208463, 1'b0, 1'b1, 32'h0);
        addv(mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3),         1, 32'h00208163, 1'b1, 1'b1, 32'h0);
        addv(mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4096),      1, 32'h80208063, 1'b1, 1'b1, 32'h0);
        addv(mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4094),      1, 32'h7E208FE3, 1'b0, 1'b1, 32'h0);
        addv(mk(3'd6, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF),  2, 32'h123462B7, 1'b0, 1'b0, 32'hFFF28293);
        addv(mk(3'd6, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001000),  1, 32'h000012B7, 1'b0, 1'b1, 32'h0);
        addv(mk(3'd6, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFB), 1, 32'hFFB00293, 1'b0, 1'b1, 32'h0);
        addv(mk(3'd6, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048),      2, 32'h000012B7, 1'b0, 1'b0, 32'h80028293);
        addv(mk(3'd7, 7'h13, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0),         1, 32'h00000000, 1'b1, 1'b1, 32'h0);
        addv(mk(3'd4, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE000),  1, 32'hABCDE1B7, 1'b0, 1'b1, 32'h0);
        addv(mk(3'd4, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000001),  1, 32'h000001B7, 1'b1, 1'b1, 32'h0);
        addv(mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048),      1, 32'h001000EF, 1'b0, 1'b1, 32'h0);
        addv(mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000), 1, 32'h800000EF, 1'b1, 1'b1, 32'h0);
        addv(mk(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'hDEADBEEF), 1, 32'h403100B3, 1'b0, 1'b1, 32'h0);
        addv(mk(3'd2, 7'h23, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, 32'd2047),      1, 32'h7E312FA3, 1'b0, 1'b1, 32'h0);
        addv(mk(3'd2, 7'h23, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, 32'd2048),      1, 32'h80312023, 1'b1, 1'b1, 32'h0);

        // Reset state
        #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_instr", out_instr, 32'h0);
        check("rst_err", out_err, 1'b0);
        check("rst_last", out_last, 1'b0);
        #11;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        check("rel_ready", in_ready, 1'b1);

        // Table-driven vectors
        foreach (vecs[k]) begin
            got_q.delete();
            send(vecs[k].r, waits);
            drain();
            check($sformatf("vec%0d_count", k), got_q.size(), vecs[k].n);
            if (got_q.size() >= 1) begin
                check($sformatf("vec%0d_w0", k), got_q[0].instr, vecs[k].w0);
                check($sformatf("vec%0d_e0", k), got_q[0].err, vecs[k].e0);
                check($sformatf("vec%0d_l0", k), got_q[0].last, vecs[k].l0);
            end
            if (vecs[k].n == 2 && got_q.size() == 2) begin
                check($sformatf("vec%0d_w1", k), got_q[1].instr, vecs[k].w1);
                check($sformatf("vec%0d_l1", k), got_q[1].last, 1'b1);
            end
        end

        // Backpressure with LUI held in FIRST; a competing request must not be taken.
        got_q.delete();
        ready_ctl = 1'b0;
        send(vecs[7].r, waits);
        cur      = vecs[0].r;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_valid", out_valid, 1'b1);
            check("bp_instr", out_instr, 32'h123462B7);
            check("bp_last", out_last, 1'b0);
            check("bp_err", out_err, 1'b0);
            check("bp_ready", in_ready, 1'b0);
        end
        @(posedge clk);
        #2;
        in_valid  = 1'b0;
        ready_ctl = 1'b1;
        drain();
        check("bp_count", got_q.size(), 2);
        if (got_q.size() == 2) check("bp_addi", got_q[1].instr, 32'hFFF28293);

        // Back-to-back single-word requests: no stall cycles, none dropped.
        got_q.delete();
        for (int k = 0; k < 8; k++) begin
            send(mk(3'd1, 7'h13, 5'($urandom()), 5'($urandom()), 5'd0, 3'($urandom()), 7'd0,
                    $urandom_range(0, 4095) - 2048), waits);
            check("b2b_stall", waits, 0);
        end
        drain();
        check("b2b_count", got_q.size(), 8);

        // Reset while FIRST is held: out_valid drops at once, ADDI never appears.
        ready_ctl = 1'b0;
        send(vecs[7].r, waits);
        check("pre_rst_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", out_valid, 1'b0);
        exp_q.delete();
        got_q.delete();
        @(posedge clk);
        #2;
        rst_n     = 1'b1;
        ready_ctl = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_no_addi", got_q.size(), 0);
        check("rst_idle_valid", out_valid, 1'b0);
        @(posedge clk);
        #2;

        // Randomized requests under random backpressure
        rand_mode = 1'b1;
        for (int k = 0; k < 400; k++) begin
            send(rand_req(), waits);
        end
        drain();
        rand_mode = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
